sub_div_ctrl: RTL



---
 rtl/sub_div_ctrl.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/sub_div_ctrl.sv
// rtl/sub_div_ctrl.sv - multi-cycle unsigned restoring divider around a16bitsub
//
// Purpose: unsigned N/N divide unit with a start/done handshake. One trial
// subtraction per cycle through a single 16-bit ripple subtractor, N cycles
// per operation, then a one-cycle DONE state that presents the results.
//
// Ports (sub_div_ctrl):
//   clk        in   clock, all state updates on the rising edge
//   rst        in   synchronous active-high reset
//   start      in   request, sampled only while idle
//   dividend   in   N  unsigned dividend, captured on accepted start
//   divisor    in   N  unsigned divisor, captured on accepted start
//   busy       out  high while iterating
//   done       out  one-cycle pulse, results valid from this cycle on
//   quotient   out  N  registered quotient, held until the next done
//   remainder  out  N  registered remainder, held until the next done
//   dbz        out  registered divide-by-zero flag
//
// Optional feature macro: SUBDIV_DBZ_EN
//   defined   : divisor==0 short-circuits to DONE in one cycle and sets dbz
//   undefined : divisor==0 runs the normal sequence, dbz tied to 0

module a16bitsub (
    input  logic [15:0] a_i,
    input  logic [15:0] b_i,
    input  logic        bin_i,
    output logic [15:0] diff_o,
    output logic        bout_o
);
    // Borrow chain: bw[i] is the borrow into bit i.
    logic [16:0] bw;

    assign bw[0] = bin_i;

    genvar i;
    generate
        for (i = 0; i < 16; i++) begin : g_fs
            assign diff_o[i] = a_i[i] ^ b_i[i] ^ bw[i];
            assign bw[i+1]   = (~a_i[i] & b_i[i]) | (~(a_i[i] ^ b_i[i]) & bw[i]);
        end
    endgenerate

    assign bout_o = bw[16];
endmodule

module sub_div_ctrl #(
    parameter int N = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder,
    output logic         dbz
);
    localparam int CW = $clog2(N);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t        state_q;
    logic [N-1:0]  q_q;       // dividend shifting out / quotient shifting in
    logic [N-1:0]  d_q;       // captured divisor
    logic [N:0]    r_q;       // partial remainder, one guard bit
    logic [CW-1:0] cnt_q;
    logic          busy_q;
    logic          done_q;
    logic [N-1:0]  quot_q;
    logic [N-1:0]  rem_q;

    // Per-iteration datapath
    logic [N:0]    rs_d;
    logic [N-1:0]  sub_d;
    logic          bo_d;
    logic          take_d;
    logic [N:0]    r_d;
    logic [N-1:0]  q_d;

    a16bitsub u_sub (
        .a_i    (rs_d[N-1:0]),
        .b_i    (d_q),
        .bin_i  (1'b0),
        .diff_o (sub_d),
        .bout_o (bo_d)
    );

    always_comb begin
        rs_d   = {r_q[N-1:0], q_q[N-1]};
        // A set guard bit means the shifted remainder exceeds any N-bit divisor.
        take_d = rs_d[N] | ~bo_d;
        r_d    = take_d ? {1'b0, sub_d} : rs_d;
        q_d    = {q_q[N-2:0], take_d};
    end

`ifdef SUBDIV_DBZ_EN
    logic dbz_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            q_q     <= '0;
            d_q     <= '0;
            r_q     <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            quot_q  <= '0;
            rem_q   <= '0;
`ifdef SUBDIV_DBZ_EN
            dbz_q   <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        q_q   <= dividend;
                        d_q   <= divisor;
                        r_q   <= '0;
                        cnt_q <= CW'(N - 1);
`ifdef SUBDIV_DBZ_EN
                        if (divisor == '0) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                            quot_q  <= '1;
                            rem_q   <= dividend;
                            dbz_q   <= 1'b1;
                        end else begin
                            state_q <= S_CALC;
                            busy_q  <= 1'b1;
                        end
`else
                        state_q <= S_CALC;
                        busy_q  <= 1'b1;
`endif
                    end
                end
                S_CALC: begin
                    r_q <= r_d;
                    q_q <= q_d;
                    if (cnt_q == '0) begin
                        // Results are published on the edge that enters DONE.
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        quot_q  <= q_d;
                        rem_q   <= r_d[N-1:0];
`ifdef SUBDIV_DBZ_EN
                        dbz_q   <= 1'b0;
`endif
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign quotient  = quot_q;
    assign remainder = rem_q;
`ifdef SUBDIV_DBZ_EN
    assign dbz       = dbz_q;
`else
    assign dbz       = 1'b0;
`endif

endmodule
